mu0_datapath: RTL
=================

Name: mu0_datapath

Overview:
- MU0 datapath, the direct neighbour of the MU0 control unit.
- Holds the PC, IR and Acc registers, the X/Y/address muxes and the 4-function ALU. Acts on the control unit's enable, select and ALU-op outputs.
- Returns F (IR[15:12]), N and Z to the control unit. Drives the memory address and write-data buses.
- Adds a retired-instruction counter for debug.

Parameters:
- DATA_W, 16, data/instruction/Acc width
- ADDR_W, 12, address width; PC width; IR operand field is IR[ADDR_W-1:0]
- RESET_PC, 0, PC value loaded on reset

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  synchronous, active-high reset
- PC_En  in  1  load PC from ALU result
- IR_En  in  1  load IR from Data_in
- Acc_En  in  1  load Acc from ALU result
- X_sel  in  1  X operand / Data_out: 0 Acc, 1 PC (zero-extended)
- Y_sel  in  1  Y operand: 0 Data_in, 1 IR[ADDR_W-1:0] (zero-extended)
- Addr_sel  in  1  Address: 0 PC, 1 IR[ADDR_W-1:0]
- M  in  2  ALU op: 0 Y, 1 X+Y, 2 X+1, 3 X-Y
- Halted  in  1  processor stopped; freezes instruction counter
- Data_in  in  DATA_W  memory read data
- Address  out  ADDR_W  memory address
- Data_out  out  DATA_W  memory write data (= X mux output)
- F  out  4  IR[DATA_W-1:DATA_W-4]
- N  out  1  Acc[DATA_W-1]
- Z  out  1  Acc == 0
- PC_dbg  out  ADDR_W  PC register
- Acc_dbg  out  DATA_W  Acc register
- IR_dbg  out  DATA_W  IR register
- Instr_count  out  16  retired-instruction counter

Behaviour:
- All state updates on rising Clk. Reset is synchronous and takes priority over every enable.
- Reset values:
  - PC = RESET_PC; IR = 0; Acc = 0; Instr_count = 0.
  - Hence F = 0, N = 0, Z = 1 in the cycle after reset.
- Combinational paths, no added latency:
  - X = X_sel ? {0, PC} : Acc.
  - Y = Y_sel ? {0, IR[ADDR_W-1:0]} : Data_in.
  - Address = Addr_sel ? IR[ADDR_W-1:0] : PC.
  - Data_out = X.
- ALU, result DATA_W bits, modulo 2^DATA_W, no carry or overflow flag:
  - M=0 → Y
  - M=1 → X+Y
  - M=2 → X+1
  - M=3 → X-Y
- Register loads:
  - PC_En: PC ← ALU[ADDR_W-1:0]. Upper bits are discarded, so PC wraps 0xFFF→0x000 on X+1.
  - IR_En: IR ← Data_in.
  - Acc_En: Acc ← ALU.
  - Simultaneous enables all load in the same edge from the same pre-edge values, e.g. PC_En+Acc_En both take one ALU result.
- Flags: N and Z come from the Acc register, not the ALU. They change only in the cycle after an Acc load.
- Instruction counter:
  - Increments by 1 on every edge where IR_En=1 and Halted=0. Wraps 0xFFFF→0.
  - Held while Halted=1. Cleared only by Reset.
- Reset mid-instruction (e.g. asserted in an execute cycle with Acc_En=1): the reset values win and no partial load occurs.
- No internal FSM: sequencing is owned by the control unit. The datapath must accept any enable combination on any cycle.

Decomposition:
- Package mu0_pkg:
  - ALU op constants ALU_Y, ALU_ADD, ALU_INC, ALU_SUB.
  - Opcode constants LDA, STA, ADD, SUB, JMP, JGE, JNE, STP (0-7).
  - Default DATA_W and ADDR_W.
- One sub-module, mu0_alu: combinational, takes X, Y, M and returns the result.
- Registers, muxes and counter stay in mu0_datapath.

Test Plan:
- Reset with all enables = 1 and Data_in = 0xFFFF → next cycle PC=0, IR=0, Acc=0, Instr_count=0, Z=1, N=0.
- Fetch: PC=0x005, Addr_sel=0, X_sel=1, M=2, PC_En=IR_En=1, Data_in=0x2123 → Address=0x005; next cycle PC=0x006, IR=0x2123, F=2, Instr_count=1.
- ADD overflow: Acc=0x7FFF, Y_sel=0, Data_in=0x0001, X_sel=0, M=1, Acc_En=1 → Acc=0x8000, N=1, Z=0. Then SUB with Data_in=0x8000, M=3 → Acc=0x0000, Z=1, N=0.
- Jump and store: IR=0x4ABC, Y_sel=1, M=0, PC_En=1 → PC=0xABC. Then Addr_sel=1 with IR=0x1ABC → Address=0xABC and Data_out=Acc with X_sel=0.
- PC wrap: PC=0xFFF, M=2, X_sel=1, PC_En=1 → PC=0x000.
- Halt and mid-op reset:
  - Halted=1 with IR_En=1 for 3 cycles → Instr_count unchanged.
  - Reset asserted together with Acc_En=1, M=0, Data_in=0x1234 → Acc=0, not 0x1234.

Source files
------------

// File: rtl/mu0_pkg.sv
// mu0_pkg: shared MU0 widths, ALU op codes and opcode constants
package mu0_pkg;
  localparam int MU0_DATA_W = 16;
  localparam int MU0_ADDR_W = 12;
  localparam logic [1:0] ALU_Y   = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_INC = 2'd2;
  localparam logic [1:0] ALU_SUB = 2'd3;
  localparam logic [3:0] LDA = 4'd0;
  localparam logic [3:0] STA = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;
  localparam logic [3:0] JMP = 4'd4;
  localparam logic [3:0] JGE = 4'd5;
  localparam logic [3:0] JNE = 4'd6;
  localparam logic [3:0] STP = 4'd7;
endpackage

// File: rtl/mu0_datapath_if.sv
// mu0_datapath_if: control-unit enables/selects, memory buses and status/debug outputs of the MU0 datapath
interface mu0_datapath_if #(parameter int DATA_W = 16, parameter int ADDR_W = 12);
  logic              PC_En, IR_En, Acc_En, X_sel, Y_sel, Addr_sel, Halted;
  logic [1:0]        M;
  logic [DATA_W-1:0] Data_in, Data_out, Acc_dbg, IR_dbg;
  logic [ADDR_W-1:0] Address, PC_dbg;
  logic [3:0]        F;
  logic              N, Z;
  logic [15:0]       Instr_count;
  modport master (
    output PC_En, IR_En, Acc_En, X_sel, Y_sel, Addr_sel, Halted, M, Data_in,
    input  Address, Data_out, F, N, Z, PC_dbg, Acc_dbg, IR_dbg, Instr_count
  );
  modport slave (
    input  PC_En, IR_En, Acc_En, X_sel, Y_sel, Addr_sel, Halted, M, Data_in,
    output Address, Data_out, F, N, Z, PC_dbg, Acc_dbg, IR_dbg, Instr_count
  );
endinterface

// File: rtl/mu0_alu.sv
// mu0_alu: combinational 4-function ALU (Y, X+Y, X+1, X-Y), modulo 2^W, ports x, y, m in and r out
module mu0_alu
  import mu0_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   m,
  output logic [W-1:0] r
);
  always_comb r = m == ALU_Y ? y : m == ALU_ADD ? x + y : m == ALU_INC ? x + W'(1) : x - y;
endmodule

// File: rtl/mu0_datapath.sv
// mu0_datapath: MU0 PC/IR/Acc registers, X/Y/address muxes, ALU and retired-instruction counter; Clk, Reset and the bus slave modport
module mu0_datapath
  import mu0_pkg::*;
#(
  parameter int                 DATA_W   = MU0_DATA_W,
  parameter int                 ADDR_W   = MU0_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input logic             Clk,
  input logic             Reset,
  mu0_datapath_if.slave   bus
);
  localparam int PAD = DATA_W - ADDR_W;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, acc, x, y, alu_r;
  logic [15:0]       cnt;
  always_comb begin
    x = bus.X_sel ? {{PAD{1'b0}}, pc} : acc;
    y = bus.Y_sel ? {{PAD{1'b0}}, ir[ADDR_W-1:0]} : bus.Data_in;
  end
  mu0_alu #(.W(DATA_W)) u_alu (.x(x), .y(y), .m(bus.M), .r(alu_r));
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc  <= RESET_PC;
      ir  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      if (bus.PC_En) pc <= alu_r[ADDR_W-1:0];
      if (bus.IR_En) ir <= bus.Data_in;
      if (bus.Acc_En) acc <= alu_r;
      if (bus.IR_En && !bus.Halted) cnt <= cnt + 16'd1;
    end
  end
  assign bus.Address     = bus.Addr_sel ? ir[ADDR_W-1:0] : pc;
  assign bus.Data_out    = x;
  assign bus.F           = ir[DATA_W-1:DATA_W-4];
  assign bus.N           = acc[DATA_W-1];
  assign bus.Z           = acc == '0;
  assign bus.PC_dbg      = pc;
  assign bus.Acc_dbg     = acc;
  assign bus.IR_dbg      = ir;
  assign bus.Instr_count = cnt;
endmodule
